// File: rtl/fp_wb_scoreboard.sv
// fp_wb_scoreboard
//   Controller for the FP register file. It does three jobs:
//   - A scoreboard with one bit per FP register, marking registers that have
//     a write outstanding, plus a count of outstanding writes. Issue stalls
//     on RAW and WAW hazards and when the count is full.
//   - A round-robin arbiter that gives the single regfile write port to
//     either the FPU result path or the FP load path.
//   - A registered write port (fregwrite_o/frd_o/writeback_data_o) driven
//     one cycle after the accepting handshake.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   issue_*                    decode/issue request; issue_ready_o is combinational
//   fpu_wb_*                   FPU result request / accept
//   lsu_wb_*                   FP load data request / accept
//   fregwrite_o, frd_o,
//   writeback_data_o           registered regfile write port
//   busy_o                     scoreboard bits, bit i = write pending to reg i
//   out_cnt_o                  number of outstanding FP writes
//   last_grant_lsu_o           arbiter state: 1 = LSU was granted last
//
// Handshakes: a transfer happens on a rising edge where both valid and
// ready are high. A requester holds valid and its payload stable until it
// sees ready. issue_ready_o, fpu_wb_ready_o and lsu_wb_ready_o are
// combinational. The write-path readies do not depend on their own valid;
// exactly one of them is high in every cycle.
module fp_wb_scoreboard #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int MAX_OUT = 8,
  localparam int NREGS  = 2 ** AW,
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic              issue_wr_i,
  input  logic [AW-1:0]     issue_frd_i,
  input  logic [3*AW-1:0]   issue_fs_i,
  input  logic [2:0]        issue_use_i,
  output logic              issue_ready_o,
  input  logic              fpu_wb_valid_i,
  input  logic [AW-1:0]     fpu_wb_frd_i,
  input  logic [XLEN-1:0]   fpu_wb_data_i,
  output logic              fpu_wb_ready_o,
  input  logic              lsu_wb_valid_i,
  input  logic [AW-1:0]     lsu_wb_frd_i,
  input  logic [XLEN-1:0]   lsu_wb_data_i,
  output logic              lsu_wb_ready_o,
  output logic              fregwrite_o,
  output logic [AW-1:0]     frd_o,
  output logic [XLEN-1:0]   writeback_data_o,
  output logic [NREGS-1:0]  busy_o,
  output logic [CW-1:0]     out_cnt_o,
  output logic              last_grant_lsu_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_lsu_q, last_lsu_d;
  logic             fregwrite_q, fregwrite_d;
  logic [AW-1:0]    frd_q, frd_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic [AW-1:0] fs1, fs2, fs3;
  logic          src_hazard, waw_hazard, cnt_full;
  logic          issue_fire;
  logic          grant_lsu;
  logic          fpu_acc, lsu_acc;
  logic          cnt_inc, cnt_dec;

  // Issue hazard check
  assign fs1 = issue_fs_i[AW-1:0];
  assign fs2 = issue_fs_i[2*AW-1:AW];
  assign fs3 = issue_fs_i[3*AW-1:2*AW];

  assign src_hazard = (issue_use_i[0] & busy_q[fs1])
                    | (issue_use_i[1] & busy_q[fs2])
                    | (issue_use_i[2] & busy_q[fs3]);
  assign waw_hazard = issue_wr_i & busy_q[issue_frd_i];
  assign cnt_full   = issue_wr_i & (cnt_q == CW'(MAX_OUT));

  assign issue_ready_o = ~(src_hazard | waw_hazard | cnt_full);
  assign issue_fire    = issue_valid_i & issue_ready_o & issue_wr_i;

  // Write-port arbiter. The side not granted last is preferred; a lone
  // valid requester always wins. With no requester the port is parked on
  // the preferred side so that exactly one ready is high.
  always_comb begin
    grant_lsu = 1'b0;
    if (lsu_wb_valid_i && !fpu_wb_valid_i) begin
      grant_lsu = 1'b1;
    end else if (lsu_wb_valid_i == fpu_wb_valid_i) begin
      grant_lsu = ~last_lsu_q;
    end
  end

  assign fpu_wb_ready_o = ~grant_lsu;
  assign lsu_wb_ready_o = grant_lsu;
  assign fpu_acc        = fpu_wb_valid_i & ~grant_lsu;
  assign lsu_acc        = lsu_wb_valid_i & grant_lsu;

  // Registered write port and arbiter history
  always_comb begin
    fregwrite_d = fpu_acc | lsu_acc;
    frd_d       = frd_q;
    data_d      = data_q;
    last_lsu_d  = last_lsu_q;
    if (fpu_acc) begin
      frd_d      = fpu_wb_frd_i;
      data_d     = fpu_wb_data_i;
      last_lsu_d = 1'b0;
    end else if (lsu_acc) begin
      frd_d      = lsu_wb_frd_i;
      data_d     = lsu_wb_data_i;
      last_lsu_d = 1'b1;
    end
  end

  // Scoreboard. The commit clear is applied before the issue set so that
  // a simultaneous set and clear of one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (fregwrite_q) begin
      busy_d[frd_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_frd_i] = 1'b1;
    end
  end

  // Outstanding count; a commit with nothing outstanding leaves it at zero.
  assign cnt_inc = issue_fire;
  assign cnt_dec = fregwrite_q & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CW'(1);
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      cnt_q       <= '0;
      last_lsu_q  <= 1'b1;
      fregwrite_q <= 1'b0;
      frd_q       <= '0;
      data_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      last_lsu_q  <= last_lsu_d;
      fregwrite_q <= fregwrite_d;
      frd_q       <= frd_d;
      data_q      <= data_d;
    end
  end

  assign fregwrite_o      = fregwrite_q;
  assign frd_o            = frd_q;
  assign writeback_data_o = data_q;
  assign busy_o           = busy_q;
  assign out_cnt_o        = cnt_q;
  assign last_grant_lsu_o = last_lsu_q;

endmodule

// File: tb/tb_fp_wb_scoreboard.sv
// Testbench for fp_wb_scoreboard. Regfile writes expected by the bench are
// queued when a write request is accepted and compared when fregwrite_o
// shows up; scoreboard, issue-ready and arbiter behaviour are checked
// directly against bench-computed values.
module tb_fp_wb_scoreboard;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;
  localparam int CW    = 4;

  // Clock / reset
  logic clk;
  logic rst_ni;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              issue_valid, issue_wr;
  logic [AW-1:0]     issue_frd;
  logic [3*AW-1:0]   issue_fs;
  logic [2:0]        issue_use;
  logic              issue_ready;
  logic              fpu_valid, fpu_ready;
  logic [AW-1:0]     fpu_frd;
  logic [XLEN-1:0]   fpu_data;
  logic              lsu_valid, lsu_ready;
  logic [AW-1:0]     lsu_frd;
  logic [XLEN-1:0]   lsu_data;
  logic              fregwrite;
  logic [AW-1:0]     frd;
  logic [XLEN-1:0]   wb_data;
  logic [NREGS-1:0]  busy;
  logic [CW-1:0]     out_cnt;
  logic              last_grant_lsu;

  fp_wb_scoreboard dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid),
    .issue_wr_i       (issue_wr),
    .issue_frd_i      (issue_frd),
    .issue_fs_i       (issue_fs),
    .issue_use_i      (issue_use),
    .issue_ready_o    (issue_ready),
    .fpu_wb_valid_i   (fpu_valid),
    .fpu_wb_frd_i     (fpu_frd),
    .fpu_wb_data_i    (fpu_data),
    .fpu_wb_ready_o   (fpu_ready),
    .lsu_wb_valid_i   (lsu_valid),
    .lsu_wb_frd_i     (lsu_frd),
    .lsu_wb_data_i    (lsu_data),
    .lsu_wb_ready_o   (lsu_ready),
    .fregwrite_o      (fregwrite),
    .frd_o            (frd),
    .writeback_data_o (wb_data),
    .busy_o           (busy),
    .out_cnt_o        (out_cnt),
    .last_grant_lsu_o (last_grant_lsu)
  );

  // Scoreboard
  logic [AW+XLEN-1:0] exp_q[$];
  logic [AW+XLEN-1:0] exp_e;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni === 1'b1 && fregwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_spurious", 64'(fregwrite), 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wb_frd", 64'(frd), 64'(exp_e[AW+XLEN-1:XLEN]));
        chk("wb_data", 64'(wb_data), 64'(exp_e[XLEN-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
    issue_frd   = '0;
    issue_fs    = '0;
    issue_use   = '0;
    fpu_valid   = 1'b0;
    fpu_frd     = '0;
    fpu_data    = '0;
    lsu_valid   = 1'b0;
    lsu_frd     = '0;
    lsu_data    = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // Issue a writing instruction with no sources; it must be ready.
  task automatic do_issue(input logic [AW-1:0] r);
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_frd   = r;
    issue_use   = 3'b000;
    @(negedge clk);
    chk("issue_rdy", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
  endtask

  // FPU write with the LSU idle; the FPU must be accepted this cycle.
  task automatic fpu_write(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
    fpu_valid = 1'b1;
    fpu_frd   = r;
    fpu_data  = d;
    @(negedge clk);
    chk("fpu_rdy", 64'(fpu_ready), 64'd1);
    exp_q.push_back({r, d});
    tick();
    fpu_valid = 1'b0;
  endtask

  logic [AW-1:0] last_frd;
  logic          exp_lsu;

  initial begin
    rst_ni = 1'b0;
    idle_inputs();

    // Reset state
    apply_reset();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(out_cnt), 64'd0);
    chk("rst_fregwrite", 64'(fregwrite), 64'd0);
    chk("rst_frd", 64'(frd), 64'd0);
    chk("rst_data", 64'(wb_data), 64'd0);
    chk("rst_fpu_first", 64'(fpu_ready), 64'd1);
    chk("rst_lsu_rdy", 64'(lsu_ready), 64'd0);
    chk("rst_last_lsu", 64'(last_grant_lsu), 64'd1);
    tick();

    // RAW: issue frd=3, then a reader of f3 waits until after the writeback
    do_issue(5'd3);
    issue_valid = 1'b1;
    issue_wr    = 1'b0;
    issue_fs    = {5'd0, 5'd0, 5'd3};
    issue_use   = 3'b001;
    @(negedge clk);
    chk("raw_busy", 64'(busy), 64'h8);
    chk("raw_cnt", 64'(out_cnt), 64'd1);
    chk("raw_stall", 64'(issue_ready), 64'd0);
    tick();
    fpu_write(5'd3, $urandom());
    @(negedge clk);
    chk("raw_wb_lat", 64'(fregwrite), 64'd1);
    chk("raw_stall_wb", 64'(issue_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("raw_release", 64'(issue_ready), 64'd1);
    chk("raw_busy_clr", 64'(busy), 64'd0);
    chk("raw_cnt_clr", 64'(out_cnt), 64'd0);
    tick();
    issue_valid = 1'b0;
    issue_use   = 3'b000;

    // Both write paths valid every cycle: grants alternate starting at FPU
    apply_reset();
    fpu_valid = 1'b1;
    fpu_frd   = AW'($urandom_range(0, NREGS - 1));
    fpu_data  = $urandom();
    lsu_valid = 1'b1;
    lsu_frd   = AW'($urandom_range(0, NREGS - 1));
    lsu_data  = $urandom();
    for (int k = 0; k < 8; k++) begin
      exp_lsu = k[0];
      @(negedge clk);
      chk("alt_fpu_rdy", 64'(fpu_ready), 64'(!exp_lsu));
      chk("alt_lsu_rdy", 64'(lsu_ready), 64'(exp_lsu));
      if (k > 0) chk("alt_fregwrite", 64'(fregwrite), 64'd1);
      if (exp_lsu) begin
        exp_q.push_back({lsu_frd, lsu_data});
        last_frd = lsu_frd;
      end else begin
        exp_q.push_back({fpu_frd, fpu_data});
        last_frd = fpu_frd;
      end
      tick();
      if (exp_lsu) begin
        lsu_frd  = AW'($urandom_range(0, NREGS - 1));
        lsu_data = $urandom();
      end else begin
        fpu_frd  = AW'($urandom_range(0, NREGS - 1));
        fpu_data = $urandom();
      end
    end
    fpu_valid = 1'b0;
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("alt_last_wb", 64'(fregwrite), 64'd1);
    tick();
    @(negedge clk);
    chk("alt_wb_off", 64'(fregwrite), 64'd0);
    chk("alt_frd_hold", 64'(frd), 64'(last_frd));
    chk("alt_cnt_sat", 64'(out_cnt), 64'd0);
    chk("alt_busy", 64'(busy), 64'd0);
    tick();

    // MAX_OUT: eight writes outstanding stall the ninth until a commit
    for (int i = 0; i < 8; i++) do_issue(AW'(10 + i));
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_frd   = 5'd20;
    @(negedge clk);
    chk("full_cnt", 64'(out_cnt), 64'd8);
    chk("full_busy", 64'(busy), 64'h0003_FC00);
    chk("full_stall", 64'(issue_ready), 64'd0);
    tick();
    fpu_write(5'd10, $urandom());
    @(negedge clk);
    chk("full_stall_wb", 64'(issue_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("full_release", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
    @(negedge clk);
    chk("full_cnt_after", 64'(out_cnt), 64'd8);
    chk("full_busy_after", 64'(busy), 64'h0013_F800);
    tick();

    // Commit f5 on the same edge as an issue writing f5
    apply_reset();
    do_issue(5'd9);
    fpu_write(5'd5, $urandom());
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_frd   = 5'd5;
    @(negedge clk);
    chk("same_wb", 64'(fregwrite), 64'd1);
    chk("same_rdy", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
    @(negedge clk);
    chk("same_busy", 64'(busy), 64'h220);
    chk("same_cnt", 64'(out_cnt), 64'd1);
    tick();

    // Source use mask and WAW
    do_issue(5'd7);
    issue_valid = 1'b1;
    issue_wr    = 1'b0;
    issue_fs    = {5'd7, 5'd0, 5'd0};
    issue_use   = 3'b011;
    @(negedge clk);
    chk("mask_fs3", 64'(issue_ready), 64'd1);
    tick();
    issue_use = 3'b111;
    @(negedge clk);
    chk("use_fs3", 64'(issue_ready), 64'd0);
    tick();
    issue_fs  = {5'd0, 5'd7, 5'd0};
    issue_use = 3'b010;
    @(negedge clk);
    chk("use_fs2", 64'(issue_ready), 64'd0);
    tick();
    issue_use = 3'b000;
    issue_wr  = 1'b1;
    issue_frd = 5'd9;
    @(negedge clk);
    chk("waw", 64'(issue_ready), 64'd0);
    tick();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;

    // Asynchronous reset mid-stream with writes in flight
    apply_reset();
    for (int i = 4; i < 8; i++) do_issue(AW'(i));
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'hF0);
    chk("mid_cnt", 64'(out_cnt), 64'd4);
    tick();
    fpu_write(5'd4, $urandom());
    #1;
    chk("mid_wb", 64'(fregwrite), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cnt", 64'(out_cnt), 64'd0);
    chk("arst_fregwrite", 64'(fregwrite), 64'd0);
    chk("arst_frd", 64'(frd), 64'd0);
    exp_q.delete();
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("arst_fpu_first", 64'(fpu_ready), 64'd1);
    tick();

    chk("q_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
